des_round_sequencer: RTL and testbench
======================================

DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

Interface
REQ-001 Parameter: NUM_ROUNDS, default 16, number of cipher rounds per block; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  requester presents a block.
REQ-005 in_decrypt  input  1  mode, sampled on accept: 0 = encrypt, 1 = decrypt.
REQ-006 in_ready  output  1  sequencer can accept a block this cycle.
REQ-007 abort  input  1  synchronous abandon of the current block.
REQ-008 round  output  4  round index to the round-key ROM.
REQ-009 load  output  1  datapath captures the input block (IP) this cycle.
REQ-010 step  output  1  datapath applies one Feistel round with the key for round.
REQ-011 finish  output  1  datapath applies the final swap/FP into its output register.
REQ-012 out_valid  output  1  result held in the datapath output register.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement states IDLE, ROUND, FINAL and DONE.
REQ-016 in_ready SHALL be high in IDLE, and in DONE when out_ready is high; it SHALL be low in ROUND and FINAL.
REQ-017 Accept = in_valid & in_ready; load SHALL equal accept combinationally, and accept SHALL latch in_decrypt into a mode register.
REQ-018 On accept, the next state SHALL be ROUND, with the round counter at 0 (encrypt) or NUM_ROUNDS-1 (decrypt).
REQ-019 In ROUND, step SHALL be 1 every cycle; round SHALL equal the counter; the counter SHALL increment (encrypt) or decrement (decrypt) each cycle.
REQ-020 The last ROUND cycle (counter NUM_ROUNDS-1 for encrypt, 0 for decrypt) SHALL transition to FINAL; the counter SHALL NOT wrap.
REQ-021 In FINAL, finish SHALL be 1 for exactly one cycle, and the next state SHALL be DONE.
REQ-022 In DONE, out_valid SHALL be 1 and hold until out_ready; out_valid & out_ready SHALL move the state to IDLE, or to ROUND if accept occurs in the same cycle (back-to-back).
REQ-023 Latency: accept in cycle T SHALL give step in T+1..T+NUM_ROUNDS, finish in T+NUM_ROUNDS+1, and out_valid from T+NUM_ROUNDS+2.
REQ-024 round SHALL be 0 in IDLE, FINAL and DONE; load, step and finish SHALL be mutually exclusive except load in DONE (with out_ready, starting the next block).
REQ-025 abort SHALL force the next state to IDLE from any state and take priority over accept; outputs already asserted in the abort cycle SHALL be unaffected.
REQ-026 A mode change on in_decrypt after accept SHALL have no effect on the block in progress.

Reset
REQ-027 rst_n low SHALL immediately set state IDLE, counter 0 and mode 0, with load, step, finish, out_valid and busy at 0 and in_ready at 1 once rst_n is released.
REQ-028 Reset mid-block SHALL discard the block with no finish or out_valid pulse.

Structure
REQ-029 The state encoding and DES_ROUNDS = 16 SHALL live in a shared des package.
REQ-030 The round counter SHALL be one sub-module, des_round_counter (load value, up/down, terminal flag); the FSM SHALL be in this module.

Verification
REQ-031 Encrypt: accept at T with in_decrypt=0 -> round 0..15 on step cycles T+1..T+16, finish at T+17, out_valid at T+18 (key 64'h133457799BBCDFF1, pt 64'h0123456789ABCDEF -> ct 64'h85E813540F0AB405 with the full datapath).
REQ-032 Decrypt: in_decrypt=1 -> round 15..0 on step cycles; the decrypted ct SHALL equal the original pt.
REQ-033 Backpressure and back-to-back: out_ready held low 5 cycles -> out_valid stays high and in_ready stays low; out_ready=1 with in_valid=1 -> load and next ROUND with no IDLE cycle.
REQ-034 Abort at step 7 -> state IDLE next cycle, no finish or out_valid pulse, and a fresh accept then completes normally.
REQ-035 rst_n low at step 10 -> all outputs 0 asynchronously (before the next clock edge), and after release in_ready=1 and round=0.
REQ-036 NUM_ROUNDS=1 -> a single step with round 0 (encrypt) or 0 (decrypt), finish at T+2, out_valid at T+3.

Source files
------------

// File: rtl/des_round_sequencer_pkg.sv
// Shared DES sequencing definitions: round count, FSM state encoding and the
// round-counter start value for each cipher direction.
package des_round_sequencer_pkg;

  localparam int unsigned DES_ROUNDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } des_state_e;

  function automatic logic [3:0] round_start(input logic decrypt, input int unsigned n);
    return decrypt ? 4'(n - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/des_round_counter.sv
// Round index counter: loadable, counts up (encrypt) or down (decrypt) and
// flags the last round of the block in the current direction.
module des_round_counter
  import des_round_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = DES_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       down,
  output logic [3:0] count,
  output logic       last
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (load) count_d = load_val;
    else if (en)   count_d = down ? count_q - 4'd1 : count_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign last  = down ? (count_q == '0) : (count_q == LAST_IDX);

endmodule

// File: rtl/des_round_sequencer.sv
// DES round sequencer: accepts a block, steps the Feistel datapath through
// NUM_ROUNDS rounds, issues the final swap/FP, then holds the result.
module des_round_sequencer
  import des_round_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = DES_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_decrypt,
  output logic       in_ready,
  input  logic       abort,
  output logic [3:0] round,
  output logic       load,
  output logic       step,
  output logic       finish,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  des_state_e state_q, state_d;
  logic       mode_q, mode_d;
  logic       accept;
  logic [3:0] cnt;
  logic       cnt_last;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign in_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (accept) mode_d = in_decrypt;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ROUND;
      ST_ROUND: if (cnt_last) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = accept ? ST_ROUND : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Counter clears whenever the next state leaves ROUND, so it never wraps.
  des_round_counter #(.NUM_ROUNDS(NUM_ROUNDS)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_d != ST_ROUND),
    .load     (accept),
    .load_val (round_start(in_decrypt, NUM_ROUNDS)),
    .en       (state_q == ST_ROUND),
    .down     (mode_q),
    .count    (cnt),
    .last     (cnt_last)
  );

  assign load      = accept;
  assign step      = (state_q == ST_ROUND);
  assign finish    = (state_q == ST_FINAL);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign round     = step ? cnt : '0;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer (NUM_ROUNDS=16 and NUM_ROUNDS=1).
module tb_des_round_sequencer;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_decrypt, abort, out_ready;

  logic       ir16, ld16, st16, fi16, ov16, bs16;
  logic [3:0] rd16;
  logic       ir1, ld1, st1, fi1, ov1, bs1;
  logic [3:0] rd1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  des_round_sequencer dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_decrypt(in_decrypt),
    .in_ready(ir16), .abort(abort), .round(rd16), .load(ld16), .step(st16),
    .finish(fi16), .out_valid(ov16), .out_ready(out_ready), .busy(bs16)
  );

  des_round_sequencer #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_decrypt(in_decrypt),
    .in_ready(ir1), .abort(abort), .round(rd1), .load(ld1), .step(st1),
    .finish(fi1), .out_valid(ov1), .out_ready(out_ready), .busy(bs1)
  );

  // Output vector order: {in_ready, load, step, finish, out_valid, busy, round}
  function automatic logic [9:0] ex(bit ir, bit ld, bit st, bit fi, bit ov, bit bs,
                                    logic [3:0] rd);
    return {ir, ld, st, fi, ov, bs, rd};
  endfunction

  function automatic logic [9:0] o16();
    return {ir16, ld16, st16, fi16, ov16, bs16, rd16};
  endfunction

  function automatic logic [9:0] o1();
    return {ir1, ld1, st1, fi1, ov1, bs1, rd1};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; abort = 1'b0; out_ready = 1'b0;
    #3;
    chk("reset_held", o16(), ex(0,0,0,0,0,0,4'd0));
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chk("reset_release", o16(), ex(1,0,0,0,0,0,4'd0));

    // Encrypt block with mode flipped after accept
    cyc();
    in_valid = 1'b1; in_decrypt = 1'b0; #1;
    chk("enc_accept", o16(), ex(1,1,0,0,0,0,4'd0));
    cyc();
    in_valid = 1'b0; in_decrypt = 1'b1; #1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("enc_step%0d", i), o16(), ex(0,0,1,0,0,1,4'(i)));
      cyc();
    end
    chk("enc_finish", o16(), ex(0,0,0,1,0,1,4'd0));
    cyc();
    chk("enc_done", o16(), ex(0,0,0,0,1,1,4'd0));

    // Backpressure: result held, no accept while out_ready low
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("bp_hold%0d", i), o16(), ex(0,0,0,0,1,1,4'd0));
    end

    // Back-to-back decrypt
    out_ready = 1'b1; in_decrypt = 1'b1; #1;
    chk("b2b_accept", o16(), ex(1,1,0,0,1,1,4'd0));
    cyc();
    in_valid = 1'b0; out_ready = 1'b0; in_decrypt = 1'b0; #1;
    for (int i = 15; i >= 0; i--) begin
      chk($sformatf("dec_step%0d", i), o16(), ex(0,0,1,0,0,1,4'(i)));
      cyc();
    end
    chk("dec_finish", o16(), ex(0,0,0,1,0,1,4'd0));
    cyc();
    chk("dec_done", o16(), ex(0,0,0,0,1,1,4'd0));
    out_ready = 1'b1; #1;
    chk("dec_drain", o16(), ex(1,0,0,0,1,1,4'd0));
    cyc();
    out_ready = 1'b0; #1;
    chk("dec_idle", o16(), ex(1,0,0,0,0,0,4'd0));

    // Abort at step 7
    in_valid = 1'b1; in_decrypt = 1'b0; #1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    abort = 1'b1; #1;
    chk("abort_cycle", o16(), ex(0,0,1,0,0,1,4'd7));
    cyc();
    abort = 1'b0; #1;
    chk("abort_idle", o16(), ex(1,0,0,0,0,0,4'd0));
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk($sformatf("abort_quiet%0d", i), o16(), ex(1,0,0,0,0,0,4'd0));
    end
    in_valid = 1'b1; #1;
    chk("reacc_accept", o16(), ex(1,1,0,0,0,0,4'd0));
    cyc();
    in_valid = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("reacc_step%0d", i), o16(), ex(0,0,1,0,0,1,4'(i)));
      cyc();
    end
    chk("reacc_finish", o16(), ex(0,0,0,1,0,1,4'd0));
    cyc();
    chk("reacc_done", o16(), ex(0,0,0,0,1,1,4'd0));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0; #1;
    chk("reacc_idle", o16(), ex(1,0,0,0,0,0,4'd0));

    // Reset at step 10
    in_valid = 1'b1; #1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("rst_pre_step10", o16(), ex(0,0,1,0,0,1,4'd10));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", o16(), ex(0,0,0,0,0,0,4'd0));
    cyc();
    chk("rst_held_edge", o16(), ex(0,0,0,0,0,0,4'd0));
    rst_n = 1'b1; #1;
    chk("rst_after", o16(), ex(1,0,0,0,0,0,4'd0));
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("rst_quiet%0d", i), o16(), ex(1,0,0,0,0,0,4'd0));
    end

    // NUM_ROUNDS=1 instance: encrypt then back-to-back decrypt
    in_valid = 1'b1; in_decrypt = 1'b0; #1;
    chk("n1_accept", o1(), ex(1,1,0,0,0,0,4'd0));
    cyc();
    in_valid = 1'b0; #1;
    chk("n1_step", o1(), ex(0,0,1,0,0,1,4'd0));
    cyc();
    chk("n1_finish", o1(), ex(0,0,0,1,0,1,4'd0));
    cyc();
    chk("n1_done", o1(), ex(0,0,0,0,1,1,4'd0));
    in_valid = 1'b1; in_decrypt = 1'b1; out_ready = 1'b1; #1;
    chk("n1_b2b", o1(), ex(1,1,0,0,1,1,4'd0));
    cyc();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("n1_dec_step", o1(), ex(0,0,1,0,0,1,4'd0));
    cyc();
    chk("n1_dec_finish", o1(), ex(0,0,0,1,0,1,4'd0));
    cyc();
    chk("n1_dec_done", o1(), ex(0,0,0,0,1,1,4'd0));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0; #1;
    chk("n1_idle", o1(), ex(1,0,0,0,0,0,4'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
